// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the CPU instruction/data SRAM-port arbiter.
// Includes FSM states, owner tags and access-size codes.
package cpu_sram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;
    typedef logic       owner_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_INST = 2'd1;
    localparam arb_state_t ARB_DATA = 2'd2;

    localparam owner_t OWNER_INST = 1'b0;
    localparam owner_t OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cpu_sram_arbiter_owner_fifo.sv
// In-order record of which master issued each outstanding memory request.
// The head entry steers the next returning response.
module mem_arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic push_i,
    input  logic push_owner_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] slot_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = slot_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                slot_q[wr_ptr_q] <= push_owner_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one split-phase SRAM port between fetch and load/store, data first.
// Grants lock until the address handshake; responses are steered in issue order.
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [1:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_addr_ok_i,
    input  logic              mem_data_ok_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_unexp_rsp_o
);
    arb_state_t state_q, state_d;
    logic       err_q, err_d;
    logic       sel_data;
    logic       sel_inst;
    logic       req_sel;
    logic       addr_hs;
    logic       rsp_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;

    always_comb begin
        sel_data = 1'b0;
        sel_inst = 1'b0;
        case (state_q)
            ARB_DATA: sel_data = 1'b1;
            ARB_INST: sel_inst = 1'b1;
            default: begin
                sel_data = data_req_i;
                sel_inst = ~data_req_i & inst_req_i;
            end
        endcase
    end

    // Full is based on the registered count, so mem_data_ok never reaches mem_req.
    assign req_sel   = (sel_data & data_req_i) | (sel_inst & inst_req_i);
    assign mem_req_o = req_sel & ~fifo_full & ~reset_i;
    assign addr_hs   = mem_req_o & mem_addr_ok_i;

    assign data_addr_ok_o = addr_hs & sel_data;
    assign inst_addr_ok_o = addr_hs & sel_inst;

    assign mem_wr_o    = sel_data & data_wr_i;
    assign mem_size_o  = sel_data ? data_size_i  : SIZE_WORD;
    assign mem_addr_o  = sel_data ? data_addr_i  : inst_addr_i;
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign rsp_pop        = mem_data_ok_i & ~fifo_empty & ~reset_i;
    assign data_data_ok_o = rsp_pop & (fifo_head == OWNER_DATA);
    assign inst_data_ok_o = rsp_pop & (fifo_head == OWNER_INST);
    assign data_rdata_o   = mem_rdata_i;
    assign inst_rdata_o   = mem_rdata_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_DATA, ARB_INST: begin
                if (addr_hs) state_d = ARB_IDLE;
            end
            default: begin
                if (addr_hs)       state_d = ARB_IDLE;
                else if (sel_data) state_d = ARB_DATA;
                else if (sel_inst) state_d = ARB_INST;
                else               state_d = ARB_IDLE;
            end
        endcase
    end

    assign err_d           = err_q | (mem_data_ok_i & fifo_empty);
    assign err_unexp_rsp_o = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (addr_hs),
        .push_owner_i (sel_data),
        .pop_i        (rsp_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_cpu_sram_arbiter;
    localparam int MAXO = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic        inst_addr_ok_o;
    logic        inst_data_ok_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i;
    logic        data_wr_i;
    logic [1:0]  data_size_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_addr_ok_o;
    logic        data_data_ok_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_wr_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_addr_ok_i;
    logic        mem_data_ok_i;
    logic [31:0] mem_rdata_i;
    logic        err_unexp_rsp_o;

    int errors = 0;
    int checks = 0;

    cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAXO)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .inst_req_i      (inst_req_i),
        .inst_addr_i     (inst_addr_i),
        .inst_addr_ok_o  (inst_addr_ok_o),
        .inst_data_ok_o  (inst_data_ok_o),
        .inst_rdata_o    (inst_rdata_o),
        .data_req_i      (data_req_i),
        .data_wr_i       (data_wr_i),
        .data_size_i     (data_size_i),
        .data_addr_i     (data_addr_i),
        .data_wdata_i    (data_wdata_i),
        .data_addr_ok_o  (data_addr_ok_o),
        .data_data_ok_o  (data_data_ok_o),
        .data_rdata_o    (data_rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_wr_o        (mem_wr_o),
        .mem_size_o      (mem_size_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_addr_ok_i   (mem_addr_ok_i),
        .mem_data_ok_i   (mem_data_ok_i),
        .mem_rdata_i     (mem_rdata_i),
        .err_unexp_rsp_o (err_unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req_i    = 1'b0;
        inst_addr_i   = '0;
        data_req_i    = 1'b0;
        data_wr_i     = 1'b0;
        data_size_i   = 2'd0;
        data_addr_i   = '0;
        data_wdata_i  = '0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b0;
        mem_rdata_i   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i       = 1'b1;
        inst_req_i    = 1'b1;
        data_req_i    = 1'b1;
        mem_addr_ok_i = 1'b1;
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if ({mem_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {mem_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o});
        end
        cyc();
        clear_inputs();
        reset_i = 1'b0;
        #4;
        checks++;
        if (err_unexp_rsp_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: err=%b mem_req=%b want 0 0", err_unexp_rsp_o, mem_req_o);
        end
        cyc();
    endtask

    task automatic test_lone_fetch();
        inst_req_i    = 1'b1;
        inst_addr_i   = 32'hBFC0_0000;
        mem_addr_ok_i = 1'b1;
        #4;
        checks++;
        if (inst_addr_ok_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'hBFC0_0000 ||
            mem_size_o !== 2'd2 || mem_wr_o !== 1'b0 || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL fetch_addr: ok=%b req=%b addr=%h size=%0d wr=%b wdata=%h want 1 1 bfc00000 2 0 0",
                     inst_addr_ok_o, mem_req_o, mem_addr_o, mem_size_o, mem_wr_o, mem_wdata_o);
        end
        cyc();
        inst_req_i    = 1'b0;
        mem_addr_ok_i = 1'b0;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b0 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early: inst_data_ok=%b data_data_ok=%b want 0 0", inst_data_ok_o, data_data_ok_o);
        end
        cyc();
        mem_data_ok_i = 1'b1;
        mem_rdata_i   = 32'h3C01_0001;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b1 || inst_rdata_o !== 32'h3C01_0001 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data: ok=%b rdata=%h data_ok=%b want 1 3c010001 0",
                     inst_data_ok_o, inst_rdata_o, data_data_ok_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_priority();
        inst_req_i    = 1'b1;
        inst_addr_i   = 32'h1000;
        data_req_i    = 1'b1;
        data_wr_i     = 1'b0;
        data_size_i   = 2'd2;
        data_addr_i   = 32'h2000;
        mem_addr_ok_i = 1'b1;
        #4;
        checks++;
        if (mem_addr_o !== 32'h2000 || data_addr_ok_o !== 1'b1 || inst_addr_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_first: addr=%h d_ok=%b i_ok=%b want 2000 1 0", mem_addr_o, data_addr_ok_o, inst_addr_ok_o);
        end
        cyc();
        data_req_i = 1'b0;
        #4;
        checks++;
        if (mem_addr_o !== 32'h1000 || inst_addr_ok_o !== 1'b1 || data_addr_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_second: addr=%h i_ok=%b d_ok=%b want 1000 1 0", mem_addr_o, inst_addr_ok_o, data_addr_ok_o);
        end
        cyc();
        inst_req_i    = 1'b0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1;
        mem_rdata_i   = 32'hAA;
        #4;
        checks++;
        if (data_data_ok_o !== 1'b1 || inst_data_ok_o !== 1'b0 || data_rdata_o !== 32'hAA) begin
            errors++;
            $display("FAIL prio_rsp1: d_ok=%b i_ok=%b rdata=%h want 1 0 aa", data_data_ok_o, inst_data_ok_o, data_rdata_o);
        end
        cyc();
        mem_rdata_i = 32'hBB;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b1 || data_data_ok_o !== 1'b0 || inst_rdata_o !== 32'hBB) begin
            errors++;
            $display("FAIL prio_rsp2: i_ok=%b d_ok=%b rdata=%h want 1 0 bb", inst_data_ok_o, data_data_ok_o, inst_rdata_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_lock();
        data_req_i  = 1'b1;
        data_size_i = 2'd2;
        data_addr_i = 32'h3000;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) begin
                inst_req_i  = 1'b1;
                inst_addr_i = 32'h4000;
            end
            mem_addr_ok_i = (c == 3);
            #4;
            checks++;
            if (mem_addr_o !== 32'h3000 || inst_addr_ok_o !== 1'b0 || mem_req_o !== 1'b1 ||
                data_addr_ok_o !== (c == 3)) begin
                errors++;
                $display("FAIL lock_hold c%0d: addr=%h i_ok=%b req=%b d_ok=%b want 3000 0 1 %0d",
                         c, mem_addr_o, inst_addr_ok_o, mem_req_o, data_addr_ok_o, (c == 3));
            end
            cyc();
        end
        data_req_i = 1'b0;
        #4;
        checks++;
        if (mem_addr_o !== 32'h4000 || inst_addr_ok_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: addr=%h i_ok=%b want 4000 1", mem_addr_o, inst_addr_ok_o);
        end
        cyc();
        inst_req_i    = 1'b0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1;
        mem_rdata_i   = 32'hCC;
        #4;
        checks++;
        if (data_data_ok_o !== 1'b1 || inst_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_rsp1: d_ok=%b i_ok=%b want 1 0", data_data_ok_o, inst_data_ok_o);
        end
        cyc();
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b1 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_rsp2: i_ok=%b d_ok=%b want 1 0", inst_data_ok_o, data_data_ok_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_full();
        for (int c = 0; c < 2; c++) begin
            inst_req_i    = 1'b1;
            inst_addr_i   = 32'h100 + 32'(4 * c);
            mem_addr_ok_i = 1'b1;
            #4;
            checks++;
            if (inst_addr_ok_o !== 1'b1) begin
                errors++;
                $display("FAIL full_fill c%0d: i_ok=%b want 1", c, inst_addr_ok_o);
            end
            cyc();
        end
        inst_req_i   = 1'b0;
        data_req_i   = 1'b1;
        data_wr_i    = 1'b1;
        data_size_i  = 2'd2;
        data_addr_i  = 32'h5000;
        data_wdata_i = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            mem_data_ok_i = (c == 2);
            mem_rdata_i   = 32'h11;
            #4;
            checks++;
            if (mem_req_o !== 1'b0 || data_addr_ok_o !== 1'b0 || inst_data_ok_o !== (c == 2)) begin
                errors++;
                $display("FAIL full_block c%0d: req=%b d_ok=%b i_data_ok=%b want 0 0 %0d",
                         c, mem_req_o, data_addr_ok_o, inst_data_ok_o, (c == 2));
            end
            cyc();
        end
        mem_data_ok_i = 1'b0;
        #4;
        checks++;
        if (mem_req_o !== 1'b1 || mem_wr_o !== 1'b1 || data_addr_ok_o !== 1'b1 ||
            mem_addr_o !== 32'h5000 || mem_wdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL full_free: req=%b wr=%b d_ok=%b addr=%h wdata=%h want 1 1 1 5000 12345678",
                     mem_req_o, mem_wr_o, data_addr_ok_o, mem_addr_o, mem_wdata_o);
        end
        cyc();
        data_req_i    = 1'b0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b1 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain1: i_ok=%b d_ok=%b want 1 0", inst_data_ok_o, data_data_ok_o);
        end
        cyc();
        #4;
        checks++;
        if (data_data_ok_o !== 1'b1 || inst_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain2: d_ok=%b i_ok=%b want 1 0", data_data_ok_o, inst_data_ok_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_store();
        data_req_i    = 1'b1;
        data_wr_i     = 1'b1;
        data_size_i   = 2'd0;
        data_addr_i   = 32'h3;
        data_wdata_i  = 32'hEF;
        mem_addr_ok_i = 1'b1;
        #4;
        checks++;
        if (mem_wr_o !== 1'b1 || mem_size_o !== 2'd0 || mem_wdata_o !== 32'hEF ||
            mem_addr_o !== 32'h3 || data_addr_ok_o !== 1'b1) begin
            errors++;
            $display("FAIL store_fields: wr=%b size=%0d wdata=%h addr=%h ok=%b want 1 0 ef 3 1",
                     mem_wr_o, mem_size_o, mem_wdata_o, mem_addr_o, data_addr_ok_o);
        end
        cyc();
        data_req_i    = 1'b0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if (data_data_ok_o !== 1'b1 || inst_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL store_done: d_ok=%b i_ok=%b want 1 0", data_data_ok_o, inst_data_ok_o);
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_unexpected_and_reset();
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b0 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL unexp_no_ok: i_ok=%b d_ok=%b want 0 0", inst_data_ok_o, data_data_ok_o);
        end
        cyc();
        mem_data_ok_i = 1'b0;
        #4;
        checks++;
        if (err_unexp_rsp_o !== 1'b1) begin
            errors++;
            $display("FAIL unexp_err: err=%b want 1", err_unexp_rsp_o);
        end
        inst_req_i    = 1'b1;
        inst_addr_i   = 32'h6000;
        mem_addr_ok_i = 1'b1;
        cyc();
        mem_addr_ok_i = 1'b0;
        inst_addr_i   = 32'h6004;
        cyc();
        // One fetch outstanding and the grant locked to fetch when reset arrives.
        reset_i       = 1'b1;
        data_req_i    = 1'b1;
        data_addr_i   = 32'h7000;
        mem_addr_ok_i = 1'b1;
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if ({mem_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 00000",
                     {mem_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o});
        end
        cyc();
        reset_i       = 1'b0;
        mem_addr_ok_i = 1'b0;
        mem_data_ok_i = 1'b0;
        #4;
        checks++;
        if (err_unexp_rsp_o !== 1'b0 || mem_addr_o !== 32'h7000 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_clear: err=%b addr=%h req=%b want 0 7000 1", err_unexp_rsp_o, mem_addr_o, mem_req_o);
        end
        cyc();
        inst_req_i    = 1'b0;
        data_req_i    = 1'b0;
        mem_data_ok_i = 1'b1;
        #4;
        checks++;
        if (inst_data_ok_o !== 1'b0 || data_data_ok_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_rsp: i_ok=%b d_ok=%b want 0 0", inst_data_ok_o, data_data_ok_o);
        end
        cyc();
        mem_data_ok_i = 1'b0;
        #4;
        checks++;
        if (err_unexp_rsp_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_late_err: err=%b want 1", err_unexp_rsp_o);
        end
        cyc();
    endtask

    // Transaction-level reference: who owns the port, and the issue order of accepted requests.
    task automatic test_random();
        bit          owners[$];
        int          lock_m;
        int          who;
        bit          i_pend, d_pend;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic        d_wr;
        logic [1:0]  d_size;
        bit          e_req, e_hs, e_pop, e_iok, e_dok, e_idok, e_ddok;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_size;
        logic        e_wr;

        do_reset();
        lock_m  = -1;
        i_pend  = 0;
        d_pend  = 0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        d_wr    = 1'b0;
        d_size  = 2'd0;
        for (int c = 0; c < 800; c++) begin
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend  = 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wr    = 1'($urandom_range(1));
                d_size  = 2'($urandom_range(2));
            end
            inst_req_i    = i_pend;
            inst_addr_i   = i_addr;
            data_req_i    = d_pend;
            data_addr_i   = d_addr;
            data_wdata_i  = d_wdata;
            data_wr_i     = d_wr;
            data_size_i   = d_size;
            mem_addr_ok_i = 1'($urandom_range(1));
            mem_data_ok_i = (owners.size() > 0) && ($urandom_range(2) != 0);
            mem_rdata_i   = $urandom;

            if (lock_m >= 0) who = lock_m;
            else if (d_pend) who = 1;
            else if (i_pend) who = 0;
            else who = -1;
            e_req  = ((who == 1 && d_pend) || (who == 0 && i_pend)) && (owners.size() < MAXO);
            e_hs   = e_req && mem_addr_ok_i;
            e_iok  = e_hs && who == 0;
            e_dok  = e_hs && who == 1;
            e_pop  = mem_data_ok_i && owners.size() > 0;
            e_ddok = e_pop && owners[0] == 1'b1;
            e_idok = e_pop && owners[0] == 1'b0;
            e_addr  = (who == 1) ? d_addr  : i_addr;
            e_wdata = (who == 1) ? d_wdata : 32'h0;
            e_size  = (who == 1) ? d_size  : 2'd2;
            e_wr    = (who == 1) ? d_wr    : 1'b0;

            #4;
            checks++;
            if (mem_req_o !== e_req || inst_addr_ok_o !== e_iok || data_addr_ok_o !== e_dok ||
                inst_data_ok_o !== e_idok || data_data_ok_o !== e_ddok || err_unexp_rsp_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_ctrl c%0d: req/iok/dok/idok/ddok/err=%b%b%b%b%b%b want %b%b%b%b%b0",
                         c, mem_req_o, inst_addr_ok_o, data_addr_ok_o, inst_data_ok_o, data_data_ok_o,
                         err_unexp_rsp_o, e_req, e_iok, e_dok, e_idok, e_ddok);
            end
            checks++;
            if (inst_rdata_o !== mem_rdata_i || data_rdata_o !== mem_rdata_i) begin
                errors++;
                $display("FAIL rand_rdata c%0d: inst=%h data=%h want %h", c, inst_rdata_o, data_rdata_o, mem_rdata_i);
            end
            if (e_req) begin
                checks++;
                if (mem_addr_o !== e_addr || mem_wdata_o !== e_wdata || mem_size_o !== e_size || mem_wr_o !== e_wr) begin
                    errors++;
                    $display("FAIL rand_fields c%0d: addr=%h wdata=%h size=%0d wr=%b want %h %h %0d %b",
                             c, mem_addr_o, mem_wdata_o, mem_size_o, mem_wr_o, e_addr, e_wdata, e_size, e_wr);
                end
            end

            if (e_pop) owners.delete(0);
            if (e_hs) owners.push_back(who == 1);
            if (e_hs) lock_m = -1;
            else if (who >= 0) lock_m = who;
            if (e_iok) i_pend = 0;
            if (e_dok) d_pend = 0;
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        cyc();
        test_reset();
        test_lone_fetch();
        test_priority();
        test_lock();
        test_full();
        test_store();
        test_unexpected_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
